ahb3lite_sram_slave: RTL

- AHB3-Lite slave (responder) that fronts a single-port synchronous SRAM. It is the memory-side counterpart of the cache BIU AHB3-Lite master.
- Serves the instruction- and data-cache line fills (INCR/WRAP bursts) and single accesses, including byte/half/word writes.
- Sits behind the interconnect address decoder, which drives HSEL; HREADY is the muxed bus-ready input.

---
 rtl/ahb3lite_pkg.sv | 42 ++++
 rtl/ahb3lite_sram_slave.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the byte-lane helper used by AHB slaves.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Lane mask for a transfer; a 32-bit bus only has lanes 0..3 so addr bit 2 is ignored.
  function automatic logic [7:0] ahb_byte_en(input logic [2:0] size,
                                             input logic [2:0] lsb,
                                             input int         xlen);
    logic [7:0] mask;
    logic [2:0] sh;
    case (size)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HWORD: mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0F;
      default:     mask = 8'hFF;
    endcase
    sh = (xlen == 32) ? {1'b0, lsb[1:0]} : lsb;
    ahb_byte_en = (mask << sh) & ((xlen == 32) ? 8'h0F : 8'hFF);
  endfunction

endpackage

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a single-port synchronous SRAM: zero-wait reads,
// writes committed in the data phase, one wait state on a write/read port clash.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int PHYS_ADDR_SIZE = 32,
  parameter  int MEM_SIZE       = 65536,
  localparam int MEM_ABITS      = $clog2(MEM_SIZE / (XLEN / 8))
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
  input  logic [XLEN-1:0]           HWDATA,
  output logic [XLEN-1:0]           HRDATA,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic [1:0]                HTRANS,
  input  logic                      HMASTLOCK,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN/8-1:0]         mem_be,
  output logic [MEM_ABITS-1:0]      mem_adr,
  output logic [XLEN-1:0]           mem_d,
  input  logic [XLEN-1:0]           mem_q
);

  localparam int         NB        = XLEN / 8;
  localparam int         BYTE_BITS = $clog2(NB);
  localparam int         OFF_BITS  = $clog2(MEM_SIZE);
  localparam logic [2:0] MAX_SIZE  = 3'(BYTE_BITS);

  localparam logic [1:0] IDLE_OK = 2'd0;
  localparam logic [1:0] ERR1    = 2'd1;
  localparam logic [1:0] ERR2    = 2'd2;

  logic [1:0]           state;
  logic                 wr_p1;
  logic                 wr_done_p1;
  logic                 rd_p1;
  logic [MEM_ABITS-1:0] adr_p1;
  logic [NB-1:0]        be_p1;

  logic [7:0]           size_mask;
  logic [7:0]           be_full;
  logic                 req_active;
  logic                 accept;
  logic                 addr_err;
  logic                 wr_accept;
  logic                 wr_active;
  logic                 conflict;
  logic                 rd_issue;
  logic                 unused_ok;

  assign req_active = HSEL & HTRANS[1];
  assign accept     = req_active & HREADY;
  assign size_mask  = (8'd1 << HSIZE) - 8'd1;
  assign addr_err   = (HSIZE > MAX_SIZE) | (|(HADDR[2:0] & size_mask[2:0]));
  assign be_full    = ahb_byte_en(HSIZE, HADDR[2:0], XLEN);
  assign wr_accept  = accept & HWRITE & ~addr_err;
  assign wr_active  = wr_p1 & ~wr_done_p1;
  // Conflict is judged without HREADY: during our write data phase HREADY is our own HREADYOUT.
  assign conflict   = wr_active & req_active & ~HWRITE & ~addr_err;
  assign rd_issue   = HRESETn & accept & ~HWRITE & ~addr_err & ~wr_active;

  assign HREADYOUT  = (state != ERR1) & ~conflict;
  assign HRESP      = (state != IDLE_OK) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA     = rd_p1 ? mem_q : '0;

  assign unused_ok  = ^{HBURST, HPROT, HMASTLOCK, HADDR, HTRANS, be_full, size_mask};

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_be  = '0;
    mem_adr = HADDR[OFF_BITS-1:BYTE_BITS];
    mem_d   = '0;
    if (wr_active) begin
      mem_req = 1'b1;
      mem_we  = 1'b1;
      mem_be  = be_p1;
      mem_adr = adr_p1;
      mem_d   = HWDATA;
    end else if (rd_issue) begin
      mem_req = 1'b1;
    end
  end

  // Address phase -> data phase boundary
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE_OK;
      wr_p1      <= 1'b0;
      wr_done_p1 <= 1'b0;
      rd_p1      <= 1'b0;
      adr_p1     <= '0;
      be_p1      <= '0;
    end else begin
      case (state)
        ERR1:    state <= ERR2;
        default: state <= (accept & addr_err) ? ERR1 : IDLE_OK;
      endcase
      if (HREADY) begin
        wr_p1      <= wr_accept;
        rd_p1      <= rd_issue;
        wr_done_p1 <= 1'b0;
        if (wr_accept) begin
          adr_p1 <= HADDR[OFF_BITS-1:BYTE_BITS];
          be_p1  <= be_full[NB-1:0];
        end
      end else if (wr_active) begin
        wr_done_p1 <= 1'b1;
      end
    end
  end

endmodule
